// File: rtl/fakeram_1r1w.sv
// ============================================================================
// fakeram_1r1w : behavioural 1R1W synchronous SRAM standing in for a hard macro
//                (registered read, configurable read-during-write).
//                Optional macro FAKERAM_CLEAR_ON_RESET_EN: reset also clears
//                the whole array asynchronously.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fakeram_1r1w #(
   parameter int DATA_WIDTH        = 3,
   parameter int SIZE              = 64,
   parameter int ADDR_WIDTH        = $clog2(SIZE),
   parameter     READ_DURING_WRITE = "NEW_DATA"
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  read_en,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] read_data,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data
);

   localparam logic [ADDR_WIDTH:0] DEPTH   = (ADDR_WIDTH+1)'(SIZE);
   localparam bit                  RDW_NEW = (READ_DURING_WRITE == "NEW_DATA");
   localparam bit                  RDW_OLD = (READ_DURING_WRITE == "OLD_DATA");

   generate
      if (!RDW_NEW && !RDW_OLD) begin : g_bad_rdw
         $fatal(1, "fakeram_1r1w: READ_DURING_WRITE must be \"NEW_DATA\" or \"OLD_DATA\"");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem [SIZE];
   logic                  write_ok;
   logic                  read_ok;
   logic                  rdw_hit;

   // Widen addresses by one bit so the range test also works for power-of-two SIZE.
   assign write_ok = write_en && ({1'b0, write_addr} < DEPTH);
   assign read_ok  = ({1'b0, read_addr} < DEPTH);
   assign rdw_hit  = RDW_NEW && write_ok && (write_addr == read_addr);

`ifdef FAKERAM_CLEAR_ON_RESET_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SIZE; i++) begin
            mem[i] <= '0;
         end
      end else if (write_ok) begin
         mem[write_addr] <= write_data;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (write_ok) begin
         mem[write_addr] <= write_data;
      end
   end
`endif

   // OLD_DATA falls out of the non-blocking array read; NEW_DATA needs the bypass.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         read_data <= '0;
      end else if (read_en) begin
         if (!read_ok) begin
            read_data <= '0;
         end else if (rdw_hit) begin
            read_data <= write_data;
         end else begin
            read_data <= mem[read_addr];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fakeram_1r1w.sv
// Directed self-checking bench for fakeram_1r1w: a 3x64 NEW_DATA instance and
// two 7x256 instances (NEW_DATA / OLD_DATA) sharing stimulus.
`default_nettype none

module tb_fakeram_1r1w;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   logic       s_re = 1'b0;
   logic [5:0] s_ra = '0;
   logic [2:0] s_rd;
   logic       s_we = 1'b0;
   logic [5:0] s_wa = '0;
   logic [2:0] s_wd = '0;

   logic       b_re = 1'b0;
   logic [7:0] b_ra = '0;
   logic [6:0] b_rd_new;
   logic [6:0] b_rd_old;
   logic       b_we = 1'b0;
   logic [7:0] b_wa = '0;
   logic [6:0] b_wd = '0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fakeram_1r1w #(.DATA_WIDTH(3), .SIZE(64), .READ_DURING_WRITE("NEW_DATA")) u_small (
      .clk(clk), .reset(reset),
      .read_en(s_re), .read_addr(s_ra), .read_data(s_rd),
      .write_en(s_we), .write_addr(s_wa), .write_data(s_wd)
   );

   fakeram_1r1w #(.DATA_WIDTH(7), .SIZE(256), .READ_DURING_WRITE("NEW_DATA")) u_big_new (
      .clk(clk), .reset(reset),
      .read_en(b_re), .read_addr(b_ra), .read_data(b_rd_new),
      .write_en(b_we), .write_addr(b_wa), .write_data(b_wd)
   );

   fakeram_1r1w #(.DATA_WIDTH(7), .SIZE(256), .READ_DURING_WRITE("OLD_DATA")) u_big_old (
      .clk(clk), .reset(reset),
      .read_en(b_re), .read_addr(b_ra), .read_data(b_rd_old),
      .write_en(b_we), .write_addr(b_wa), .write_data(b_wd)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with a read pending on addr 5
      s_re = 1'b1; s_ra = 6'd5;
      tick(); check("rst_hold0", 32'(s_rd), 32'd0);
      tick(); check("rst_hold1", 32'(s_rd), 32'd0);

      // Write 10=5, then read it back with one-cycle latency
      reset = 1'b0;
      s_re = 1'b0; s_we = 1'b1; s_wa = 6'd10; s_wd = 3'b101;
      tick(); check("lat_pre", 32'(s_rd), 32'd0);
      s_we = 1'b0; s_re = 1'b1; s_ra = 6'd10;
      tick(); check("rd_after_wr", 32'(s_rd), 32'd5);

      // Same-address write+read on the NEW_DATA small instance
      s_we = 1'b1; s_wa = 6'd10; s_wd = 3'd3; s_re = 1'b1; s_ra = 6'd10;
      tick(); check("byp_small", 32'(s_rd), 32'd3);

      // Address boundaries and hold with read_en low
      s_re = 1'b0; s_we = 1'b1; s_wa = 6'd0;  s_wd = 3'd1;
      tick();
      s_wa = 6'd63; s_wd = 3'd6;
      tick();
      s_we = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_ra = 6'(i * 21);
         tick(); check("hold", 32'(s_rd), 32'd3);
      end
      s_re = 1'b1; s_ra = 6'd63;
      tick(); check("rd63", 32'(s_rd), 32'd6);
      s_ra = 6'd0;
      tick(); check("rd0", 32'(s_rd), 32'd1);

      // Write and read at different addresses on the same edge
      s_re = 1'b0; s_we = 1'b1; s_wa = 6'd3; s_wd = 3'd7;
      tick();
      s_wa = 6'd4; s_wd = 3'd2; s_re = 1'b1; s_ra = 6'd3;
      tick(); check("rdw_diff", 32'(s_rd), 32'd7);
      s_we = 1'b0; s_ra = 6'd4;
      tick(); check("rd4", 32'(s_rd), 32'd2);
      s_re = 1'b0;

      // Read-during-write policy on the 7x256 pair
      b_we = 1'b1; b_wa = 8'd200; b_wd = 7'h11;
      tick();
      b_wd = 7'h5A; b_re = 1'b1; b_ra = 8'd200;
      tick();
      check("rdw_new", 32'(b_rd_new), 32'h5A);
      check("rdw_old", 32'(b_rd_old), 32'h11);
      b_wa = 8'd201; b_wd = 7'h22;
      tick();
      check("b200_new", 32'(b_rd_new), 32'h5A);
      check("b200_old", 32'(b_rd_old), 32'h5A);
      b_we = 1'b0; b_ra = 8'd201;
      tick();
      check("b201_new", 32'(b_rd_new), 32'h22);
      check("b201_old", 32'(b_rd_old), 32'h22);
      b_re = 1'b0;

      // Reset pulse: async clear of read_data, then read honoured on the first edge after release
      s_we = 1'b1; s_wa = 6'd9; s_wd = 3'd3;
      tick();
      s_we = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("rst_async", 32'(s_rd), 32'd0);
      check("rst_async_b", 32'(b_rd_new), 32'd0);
      s_re = 1'b1; s_ra = 6'd9;
      tick(); check("rst_in", 32'(s_rd), 32'd0);
      reset = 1'b0;
      tick();
`ifdef FAKERAM_CLEAR_ON_RESET_EN
      check("rst_retain", 32'(s_rd), 32'd0);
`else
      check("rst_retain", 32'(s_rd), 32'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
